// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words, writes them to
// instruction memory from address 0 and releases the CPU only after a good checksum.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_addr,
  output logic [31:0]           im_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ADDR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   addr;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [1:0]            idx;
  logic [23:0]           word;
  logic [7:0]            csum;
  logic                  count_ok;
  logic                  accept;

  assign count_ok = (num_words != '0) && (num_words <= DEPTH);
  assign accept   = byte_valid && byte_ready;
  // addr is one bit wider than im_addr so a full-depth image ends without wrapping
  assign addr_inc = addr + ADDR_ONE;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      count      <= '0;
      addr       <= '0;
      idx        <= '0;
      word       <= '0;
      csum       <= '0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            if (count_ok) begin
              state      <= S_RECV;
              count      <= num_words;
              addr       <= '0;
              idx        <= '0;
              csum       <= '0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              err        <= 1'b0;
            end else begin
              state      <= S_ERROR;
              byte_ready <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end
          end
        end

        S_RECV: begin
          if (accept) begin
            word <= {word[15:0], byte_in};
            csum <= csum ^ byte_in;
            idx  <= idx + 2'd1;
            // fourth byte completes the word; present it to memory next cycle
            if (idx == 2'd3) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              im_we      <= 1'b1;
              im_addr    <= addr[ADDR_WIDTH-1:0];
              im_wdata   <= {word, byte_in};
            end
          end
        end

        S_WRITE: begin
          addr       <= addr_inc;
          byte_ready <= 1'b1;
          state      <= (addr_inc == count) ? S_CHECK : S_RECV;
        end

        S_CHECK: begin
          if (accept) begin
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            if (byte_in == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader with an instruction-memory model
// and an image-level reference (word list, byte XOR, fixed 5-cycle-per-word timing).
module tb_imem_loader;

  localparam int unsigned AW = 8;

  typedef logic [31:0] word_q_t[$];
  typedef logic [7:0]  byte_q_t[$];

  logic          clk = 1'b0;
  logic          RESET;
  logic          start;
  logic [AW:0]   num_words;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .RESET(RESET), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // edge_n = index of the next rising edge (first edge is 0)
  int edge_n = 0;
  int viol = 0;
  int acc_cnt = 0;
  int last_acc = -1;
  logic [31:0] mem [0:(1<<AW)-1];
  int          wl_edge[$];
  int          wl_addr[$];
  logic [31:0] wl_data[$];

  always @(posedge clk) edge_n++;

  // Instruction memory and observers, sampled mid-cycle for the coming edge
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wl_edge.push_back(edge_n);
      wl_addr.push_back(int'(im_addr));
      wl_data.push_back(im_wdata);
      mem[im_addr] = im_wdata;
    end
    if (busy === 1'b1 && byte_ready === im_we) viol++;
    if (im_we === 1'b1 && busy !== 1'b1) viol++;
    if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
      acc_cnt++;
      last_acc = edge_n;
    end
  end

  function automatic logic [7:0] image_xor(input word_q_t w);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x = x ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  function automatic byte_q_t image_bytes(input word_q_t w);
    byte_q_t b;
    foreach (w[i]) begin
      b.push_back(w[i][31:24]);
      b.push_back(w[i][23:16]);
      b.push_back(w[i][15:8]);
      b.push_back(w[i][7:0]);
    end
    return b;
  endfunction

  function automatic word_q_t rand_words(input int n);
    word_q_t w;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    return w;
  endfunction

  // mode 0: valid always high, 1: toggling, 2: random gaps
  task automatic stream(input byte_q_t b, input int mode, input int budget, output bit ok);
    int i = 0;
    int n = 0;
    bit tog = 1'b1;
    bit v;
    bit acc;
    while (i < b.size() && n < budget) begin
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = !tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_in    = v ? b[i] : 8'($urandom);
      acc        = v && (byte_ready === 1'b1);
      @(posedge clk); #1;
      n++;
      if (acc) i++;
    end
    byte_valid = 1'b0;
    ok = (i == b.size());
  endtask

  task automatic clear_obs();
    wl_edge.delete();
    wl_addr.delete();
    wl_data.delete();
    acc_cnt = 0;
    viol = 0;
    last_acc = -1;
  endtask

  task automatic run_load(input word_q_t w, input logic [7:0] cs, input int mode,
                          input bit hold_start, output int e0, output bit ok);
    byte_q_t b = image_bytes(w);
    b.push_back(cs);
    clear_obs();
    start     = 1'b1;
    num_words = (AW+1)'(w.size());
    @(posedge clk); #1;
    e0 = edge_n - 1;
    if (hold_start) num_words = '0;
    else start = 1'b0;
    stream(b, mode, 20 * b.size() + 20, ok);
    start = 1'b0;
  endtask

  task automatic test_reset();
    word_q_t w;
    int e0;
    bit ok;
    byte_q_t b;
    RESET = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = '0; num_words = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b",
                               byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err); end
    RESET = 1'b0;
    @(posedge clk); #1;
    // mid-session reset after the first word is in memory
    w = rand_words(2);
    clear_obs();
    start = 1'b1; num_words = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    b = image_bytes(w);
    b = b[0:5];
    stream(b, 0, 40, ok);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err} !==
        {1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0})
      begin errors++; $display("FAIL reset_async got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b",
                               byte_ready, im_we, im_addr, im_wdata, cpu_hold, busy, done, err); end
    @(posedge clk); #1;
    RESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!ok || wl_data.size() != 1 || mem[0] !== w[0])
      begin errors++; $display("FAIL reset_partial got ok=%0d writes=%0d mem0=%h want 1 1 %h",
                               ok, wl_data.size(), mem[0], w[0]); end
    e0 = 0;
  endtask

  task automatic test_clean_load();
    word_q_t w;
    int e0;
    bit ok;
    w = '{32'h12345678, 32'h9ABCDEF0, 32'h0000000F};
    run_load(w, 8'h0F, 0, 1'b0, e0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clean_stream got timeout want complete"); end
    checks++;
    if (wl_data.size() != 3) begin errors++; $display("FAIL clean_nwrites got %0d want 3", wl_data.size()); end
    for (int k = 0; k < w.size(); k++) begin
      checks++;
      if (k >= wl_data.size()) begin errors++; $display("FAIL clean_write%0d got none want %h", k, w[k]); end
      else if (wl_addr[k] !== k || wl_data[k] !== w[k] || wl_edge[k] !== e0 + 5 * (k + 1))
        begin errors++; $display("FAIL clean_write%0d got a=%0d d=%h e=%0d want a=%0d d=%h e=%0d",
                                 k, wl_addr[k], wl_data[k], wl_edge[k], k, w[k], e0 + 5 * (k + 1)); end
    end
    checks++;
    if (last_acc !== e0 + 16) begin errors++; $display("FAIL clean_csum_edge got %0d want %0d", last_acc, e0 + 16); end
    checks++;
    if ({done, err, cpu_hold, busy, byte_ready} !== 5'b10000)
      begin errors++; $display("FAIL clean_status got done/err/hold/busy/rdy=%b want 10000",
                               {done, err, cpu_hold, busy, byte_ready}); end
  endtask

  task automatic test_gapped();
    word_q_t w;
    int e0;
    bit ok;
    w = '{32'h12345678, 32'h9ABCDEF0, 32'h0000000F};
    // start stays high throughout with an illegal count; it must be ignored mid-session
    run_load(w, 8'h0F, 1, 1'b1, e0, ok);
    checks++;
    if (!ok || wl_data.size() != 3) begin errors++; $display("FAIL gap_nwrites got ok=%0d n=%0d want 1 3", ok, wl_data.size()); end
    for (int k = 0; k < w.size(); k++) begin
      checks++;
      if (k >= wl_data.size() || wl_addr[k] !== k || wl_data[k] !== w[k])
        begin errors++; $display("FAIL gap_write%0d got n=%0d want a=%0d d=%h", k, wl_data.size(), k, w[k]); end
    end
    checks++;
    if (viol != 0 || acc_cnt != 13) begin errors++; $display("FAIL gap_ready got viol=%0d acc=%0d want 0 13", viol, acc_cnt); end
    checks++;
    if ({done, err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL gap_status got %b want 100", {done, err, cpu_hold}); end
  endtask

  task automatic test_bad_checksum();
    word_q_t w;
    int e0;
    bit ok;
    w = '{32'h12345678, 32'h9ABCDEF0, 32'h0000000F};
    run_load(w, 8'h0E, 0, 1'b0, e0, ok);
    checks++;
    if (!ok || wl_data.size() != 3) begin errors++; $display("FAIL bad_nwrites got ok=%0d n=%0d want 1 3", ok, wl_data.size()); end
    checks++;
    if ({done, err, cpu_hold, busy} !== 4'b0110) begin errors++; $display("FAIL bad_status got %b want 0110", {done, err, cpu_hold, busy}); end
    checks++;
    if (mem[0] !== w[0] || mem[1] !== w[1] || mem[2] !== w[2])
      begin errors++; $display("FAIL bad_mem_kept got %h %h %h", mem[0], mem[1], mem[2]); end
    run_load(w, 8'h0F, 2, 1'b0, e0, ok);
    checks++;
    if (!ok || {done, err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL bad_reload got ok=%0d %b want 1 100", ok, {done, err, cpu_hold}); end
  endtask

  task automatic test_count_bounds();
    word_q_t w;
    int e0;
    bit ok;
    int nbad;
    logic [AW:0] badn [2];
    badn[0] = '0;
    badn[1] = 9'd257;
    for (int j = 0; j < 2; j++) begin
      clear_obs();
      start = 1'b1; num_words = badn[j];
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if ({err, done, cpu_hold, busy, byte_ready} !== 5'b10100)
        begin errors++; $display("FAIL bounds_n%0d got err/done/hold/busy/rdy=%b want 10100", badn[j], {err, done, cpu_hold, busy, byte_ready}); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wl_data.size() != 0) begin errors++; $display("FAIL bounds_n%0d_writes got %0d want 0", badn[j], wl_data.size()); end
    end
    w = rand_words(1 << AW);
    run_load(w, image_xor(w), 0, 1'b0, e0, ok);
    checks++;
    if (!ok || wl_data.size() != (1 << AW)) begin errors++; $display("FAIL full_nwrites got ok=%0d n=%0d want 1 256", ok, wl_data.size()); end
    nbad = 0;
    for (int k = 0; k < wl_data.size() && k < w.size(); k++)
      if (wl_addr[k] !== k || wl_data[k] !== w[k]) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL full_content got %0d bad words want 0", nbad); end
    checks++;
    if (wl_addr.size() == 0 || wl_addr[wl_addr.size() - 1] !== 255)
      begin errors++; $display("FAIL full_last_addr got n=%0d want last 255", wl_addr.size()); end
    checks++;
    if ({done, err, cpu_hold} !== 3'b100) begin errors++; $display("FAIL full_status got %b want 100", {done, err, cpu_hold}); end
  endtask

  task automatic test_reset_midword();
    word_q_t w;
    byte_q_t b;
    int e0;
    bit ok;
    clear_obs();
    start = 1'b1; num_words = 9'd1;
    @(posedge clk); #1;
    start = 1'b0;
    b = '{8'hA5, 8'h5A};
    stream(b, 0, 20, ok);
    #3 RESET = 1'b1;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (wl_data.size() != 0 || {byte_ready, busy, done, err, cpu_hold} !== 5'b00001)
      begin errors++; $display("FAIL midword_idle got writes=%0d rdy/busy/done/err/hold=%b want 0 00001",
                               wl_data.size(), {byte_ready, busy, done, err, cpu_hold}); end
    w = '{32'hDEADBEEF};
    run_load(w, 8'h22, 0, 1'b0, e0, ok);
    checks++;
    if (!ok || wl_data.size() != 1 || wl_addr[0] !== 0 || wl_data[0] !== 32'hDEADBEEF || done !== 1'b1)
      begin errors++; $display("FAIL midword_reload got ok=%0d n=%0d done=%b want 1 1 1", ok, wl_data.size(), done); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      word_q_t w;
      logic [7:0] cs;
      bit good;
      int e0;
      bit ok;
      int nbad;
      int mode;
      w    = rand_words($urandom_range(1, 6));
      good = 1'($urandom_range(0, 1));
      cs   = good ? image_xor(w) : (image_xor(w) ^ 8'($urandom_range(1, 255)));
      mode = $urandom_range(0, 2);
      run_load(w, cs, mode, 1'($urandom_range(0, 1)), e0, ok);
      nbad = (wl_data.size() == w.size()) ? 0 : 1;
      for (int k = 0; k < wl_data.size() && k < w.size(); k++)
        if (wl_addr[k] !== k || wl_data[k] !== w[k]) nbad++;
      checks++;
      if (!ok || nbad != 0 || viol != 0 || acc_cnt != 4 * w.size() + 1)
        begin errors++; $display("FAIL rand%0d_stream got ok=%0d bad=%0d viol=%0d acc=%0d want 1 0 0 %0d",
                                 s, ok, nbad, viol, acc_cnt, 4 * w.size() + 1); end
      checks++;
      if ({done, err, cpu_hold, busy} !== {good, !good, !good, 1'b0})
        begin errors++; $display("FAIL rand%0d_status got %b want %b", s, {done, err, cpu_hold, busy},
                                 {good, !good, !good, 1'b0}); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_load();
    test_gapped();
    test_bad_checksum();
    test_count_bounds();
    test_reset_midword();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
